// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the ring sequence monitor
package ring_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

  // Helpers work on a fixed-width container; callers zero-extend and truncate
  localparam int MAX_WIDTH = 32;

  // Left rotation of the low w bits of prev (bit w-1 wraps into bit 0)
  function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] prev,
                                                input int w);
    logic [MAX_WIDTH-1:0] mask;
    mask = ~({MAX_WIDTH{1'b1}} << w);
    return ((prev << 1) | (prev >> (w - 1))) & mask;
  endfunction

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - MAX_WIDTH'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_sequence_monitor_onehot_encoder.sv
// rtl/ring_sequence_monitor_onehot_encoder.sv - one-hot to index encoder with valid flag
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]         onehot,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     valid
);

  localparam int IW = $clog2(WIDTH);

  // OR together the indices of set bits; meaningful only when valid is high
  always_comb begin
    index = '0;
    valid = is_onehot(MAX_WIDTH'(onehot));
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) begin
        index = index | IW'(i);
      end
    end
  end

endmodule

// File: rtl/ring_sequence_monitor.sv
// rtl/ring_sequence_monitor.sv - lock, revolution count and fault monitor for a one-hot ring counter
module ring_sequence_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = 2,
  parameter int REV_WIDTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_seq,
  input  logic                     clear_error,
  output logic                     locked,
  output logic                     error,
  output logic                     rev_tick,
  output logic [REV_WIDTH-1:0]     rev_count,
  output logic [$clog2(WIDTH)-1:0] phase_index
);

  localparam int GW = $clog2(LOCK_COUNT + 1);

  state_t                     state, state_nx;
  logic [WIDTH-1:0]           prev;
  logic [WIDTH-1:0]           expected;
  logic [GW-1:0]              good_cnt, good_nx, good_inc;
  logic [REV_WIDTH-1:0]       count_nx;
  logic                       tick_nx;
  logic                       onehot;
  logic                       match;
  logic [$clog2(WIDTH)-1:0]   hot_index;

  onehot_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .onehot (ring_seq),
    .index  (hot_index),
    .valid  (onehot)
  );

  assign expected = WIDTH'(rotl(MAX_WIDTH'(prev), WIDTH));
  assign match    = onehot && (ring_seq == expected);
  assign good_inc = good_cnt + GW'(1);

  // Next state, lock streak and revolution bookkeeping
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    tick_nx  = 1'b0;
    count_nx = rev_count;
    case (state)
      IDLE: begin
        if (onehot) begin
          state_nx = SYNC;
          good_nx  = '0;
        end
      end
      SYNC: begin
        if (!onehot) begin
          state_nx = IDLE;
        end else if (match) begin
          good_nx = good_inc;
          if (good_inc == GW'(LOCK_COUNT)) begin
            state_nx = LOCKED;
          end
        end else begin
          good_nx = '0;
        end
      end
      LOCKED: begin
        // A bad pattern on a would-be revolution edge takes the fault path only
        if (!match) begin
          state_nx = FAULT;
        end else if (prev[WIDTH-1] && (ring_seq == WIDTH'(1))) begin
          tick_nx  = 1'b1;
          count_nx = rev_count + REV_WIDTH'(1);
        end
      end
      FAULT: begin
        if (clear_error) begin
          state_nx = IDLE;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register plus registered flags derived from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prev        <= '0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      phase_index <= '0;
    end else begin
      state       <= state_nx;
      prev        <= ring_seq;
      good_cnt    <= good_nx;
      locked      <= (state_nx == LOCKED);
      error       <= (state_nx == FAULT);
      rev_tick    <= tick_nx;
      rev_count   <= count_nx;
      phase_index <= (state_nx == LOCKED) ? hot_index : '0;
    end
  end

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// tb/tb_ring_sequence_monitor.sv - self-checking bench for ring_sequence_monitor
module tb_ring_sequence_monitor;

  logic       clock;
  logic       reset;
  logic [2:0] ring_seq;
  logic       clear_error;
  logic       locked;
  logic       error;
  logic       rev_tick;
  logic [1:0] rev_count;
  logic [1:0] phase_index;

  int passed = 0;
  int total  = 0;

  ring_sequence_monitor #(
    .WIDTH      (3),
    .LOCK_COUNT (2),
    .REV_WIDTH  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ring_seq    (ring_seq),
    .clear_error (clear_error),
    .locked      (locked),
    .error       (error),
    .rev_tick    (rev_tick),
    .rev_count   (rev_count),
    .phase_index (phase_index)
  );

  initial begin
    clock = 1'b0;
    forever #50 clock = ~clock;
  end

  // Behavioural model: lock acquisition, revolutions and sticky fault
  bit         m_sync, m_lock, m_err, m_tick;
  int         m_streak, m_revs, m_phase;
  logic [2:0] m_prev;

  function automatic logic [2:0] next_phase(input logic [2:0] p);
    return (p == 3'd4) ? 3'd1 : 3'(p * 2);
  endfunction

  function automatic int index_of(input logic [2:0] s);
    return (s == 3'd1) ? 0 : (s == 3'd2) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_sync = 0; m_lock = 0; m_err = 0; m_tick = 0;
    m_streak = 0; m_revs = 0; m_phase = 0; m_prev = 3'd0;
  endtask

  task automatic model_step(input logic [2:0] s, input bit clr);
    bit oh, good;
    oh     = ($countones(s) == 1);
    good   = oh && (m_prev != 3'd0) && (s == next_phase(m_prev));
    m_tick = 0;
    if (m_err) begin
      if (clr) begin
        m_err = 0; m_revs = 0;
      end
    end else if (m_lock) begin
      if (good) begin
        if (m_prev == 3'd4) begin
          m_tick = 1;
          m_revs = (m_revs + 1) % 4;
        end
      end else begin
        m_lock = 0; m_err = 1;
      end
    end else if (m_sync) begin
      if (!oh) m_sync = 0;
      else if (good) begin
        m_streak++;
        if (m_streak == 2) begin
          m_lock = 1; m_sync = 0;
        end
      end else m_streak = 0;
    end else if (oh) begin
      m_sync = 1; m_streak = 0;
    end
    m_prev  = s;
    m_phase = m_lock ? index_of(s) : 0;
  endtask

  function automatic logic [6:0] dut_vec();
    return {locked, error, rev_tick, rev_count, phase_index};
  endfunction

  function automatic logic [6:0] model_vec();
    return {m_lock, m_err, m_tick, 2'(m_revs), 2'(m_phase)};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {lock,err,tick,cnt,ph}=%b expected %b", name, act, exp);
  endtask

  // Apply one sample on the next rising edge, then settle mid-cycle
  task automatic step(input logic [2:0] s, input bit clr);
    ring_seq    = s;
    clear_error = clr;
    @(posedge clock);
    @(negedge clock);
    model_step(s, clr);
    ring_seq    = 3'd0;
    clear_error = 1'b0;
  endtask

  task automatic step_check(input string name, input logic [2:0] s, input bit clr);
    step(s, clr);
    check(name, dut_vec(), model_vec());
  endtask

  typedef struct {
    logic [2:0] s;
    bit         clr;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // {locked, error, rev_tick, rev_count[1:0], phase_index[1:0]}
    vecs[0]  = '{3'b001, 0, 7'b0_0_0_00_00};
    vecs[1]  = '{3'b010, 0, 7'b0_0_0_00_00};
    vecs[2]  = '{3'b100, 0, 7'b1_0_0_00_10};
    vecs[3]  = '{3'b001, 0, 7'b1_0_1_01_00};
    vecs[4]  = '{3'b010, 0, 7'b1_0_0_01_01};
    vecs[5]  = '{3'b011, 0, 7'b0_1_0_01_00};
    vecs[6]  = '{3'b100, 0, 7'b0_1_0_01_00};
    vecs[7]  = '{3'b001, 0, 7'b0_1_0_01_00};
    vecs[8]  = '{3'b010, 0, 7'b0_1_0_01_00};
    vecs[9]  = '{3'b100, 0, 7'b0_1_0_01_00};
    vecs[10] = '{3'b001, 0, 7'b0_1_0_01_00};
    vecs[11] = '{3'b010, 1, 7'b0_0_0_00_00};
    vecs[12] = '{3'b100, 0, 7'b0_0_0_00_00};
    vecs[13] = '{3'b001, 0, 7'b0_0_0_00_00};
    vecs[14] = '{3'b010, 0, 7'b1_0_0_00_01};
    vecs[15] = '{3'b100, 0, 7'b1_0_0_00_10};
    vecs[16] = '{3'b001, 0, 7'b1_0_1_01_00};
    vecs[17] = '{3'b010, 1, 7'b1_0_0_01_01};

    reset = 1'b1; ring_seq = 3'd0; clear_error = 1'b0;
    model_reset();
    #10 check("during_reset", dut_vec(), 7'd0);
    #90 reset = 1'b0;
    #10 check("after_reset", dut_vec(), 7'd0);

    // Lock, revolution, fault, sticky error, clear and re-lock
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].s, vecs[i].clr);
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end

    // Bad pattern on a revolution edge: fault wins, count holds
    step_check("pre_rev", 3'b100, 0);
    step(3'b000, 0);
    check("fault_at_rev", dut_vec(), 7'b0_1_0_01_00);
    // Clear wins over a bad pattern in FAULT
    step(3'b011, 1);
    check("clear_vs_bad", dut_vec(), 7'b0_0_0_00_00);

    // Held value while locked is a fault
    step_check("hold_a", 3'b001, 0);
    step_check("hold_b", 3'b010, 0);
    step_check("hold_c", 3'b100, 0);
    step(3'b100, 0);
    check("held_value", dut_vec(), 7'b0_1_0_00_00);

    // Reverse rotation never locks and never faults
    step(3'b000, 1);
    for (int i = 0; i < 12; i++) begin
      logic [2:0] rev_pat [3];
      rev_pat = '{3'b001, 3'b100, 3'b010};
      step(rev_pat[i % 3], 0);
      check($sformatf("reverse%0d", i), {locked, error}, 2'b00);
    end

    // Wrap: five revolutions with REV_WIDTH = 2
    reset = 1'b1; #10 reset = 1'b0; model_reset();
    step(3'b001, 0); step(3'b010, 0); step(3'b100, 0);
    for (int r = 0; r < 5; r++) begin
      step(3'b001, 0);
      check($sformatf("wrap%0d", r), {rev_tick, rev_count}, {1'b1, 2'((r + 1) % 4)});
      step(3'b010, 0);
      check($sformatf("wrap_notick%0d", r), {rev_tick, rev_count}, {1'b0, 2'((r + 1) % 4)});
      step(3'b100, 0);
    end
    for (int r = 0; r < 2; r++) begin
      step(3'b001, 0); step(3'b010, 0); step(3'b100, 0);
    end
    check("pre_async", dut_vec(), 7'b1_0_0_11_10);

    // Async reset mid-cycle clears outputs before the next edge
    #10 reset = 1'b1;
    #1 check("async_reset", dut_vec(), 7'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    step_check("relock_a", 3'b001, 0);
    step_check("relock_b", 3'b010, 0);
    step(3'b100, 0);
    check("relock_c", dut_vec(), 7'b1_0_0_00_10);

    // Randomised run against the model
    begin
      logic [2:0] d;
      d = 3'b100;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 99) < 80) d = ($countones(d) == 1) ? next_phase(d) : 3'b001;
        else d = 3'($urandom_range(0, 7));
        step_check($sformatf("rand%0d", i), d, ($urandom_range(0, 9) == 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_sequence_monitor.md
Name: ring_sequence_monitor

Overview:
- Downstream consumer of the 3-bit one-hot ring counter output `sequence`.
- Checks every clock that the pattern is one-hot and advances by exactly one left-rotation.
- Acquires lock, counts full revolutions and reports the encoded phase.
- Raises a sticky fault on any corruption, so the counter can be checked on hardware as well as in simulation.

Parameters:
- WIDTH, 3: ring length; must match the upstream counter's `sequence` width.
- LOCK_COUNT, 2: consecutive correct rotations required to declare lock (≥1).
- REV_WIDTH, 8: width of the revolution counter.

Ports:
- clock  input  1  rising-edge system clock, shared with the ring counter.
- reset  input  1  asynchronous, active-high reset.
- sequence  input  WIDTH  one-hot phase from the ring counter.
- clear_error  input  1  synchronous request to clear a fault and re-acquire.
- locked  output  1  registered; high while the sequence is tracked correctly.
- error  output  1  registered; sticky fault flag.
- rev_tick  output  1  registered one-cycle pulse per completed revolution.
- rev_count  output  REV_WIDTH  registered count of completed revolutions.
- phase_index  output  clog2(WIDTH)  registered index of the hot bit; 0 when not locked.

Behaviour:
- Upstream contract, decided: the ring counter resets to 001 and rotates left each clock.
  - Rotation order is 001 → 010 → 100 → 001.
  - expected = {prev[WIDTH-2:0], prev[WIDTH-1]}.
- Reset (async, active-high):
  - state = IDLE, prev = 0, good_cnt = 0.
  - locked = error = rev_tick = 0; rev_count = 0; phase_index = 0.
  - Outputs go to these values immediately, not at the next edge.
- Every rising edge: `sequence` is sampled into prev. All decisions compare the sampled `sequence` with prev and expected. Outputs update at that same edge (1-cycle latency from input to flags).
- onehot = exactly one bit set. match = onehot && (sequence == expected).
- FSM states: IDLE, SYNC, LOCKED, FAULT.
- IDLE:
  - onehot → SYNC, good_cnt = 0.
  - otherwise stay in IDLE.
- SYNC:
  - match: good_cnt+1. If good_cnt+1 == LOCK_COUNT → LOCKED, locked = 1.
  - onehot but wrong rotation (including a held value): good_cnt = 0, stay in SYNC.
  - not onehot → IDLE.
  - error is never set in SYNC.
- LOCKED:
  - match: stay in LOCKED.
  - A revolution completes when prev[WIDTH-1] = 1 and sequence = 1. That edge sets rev_tick = 1 and increments rev_count.
  - rev_count wraps 2^REV_WIDTH-1 → 0 with no flag.
  - Any non-match (bad pattern, held value, wrong direction) → FAULT: locked = 0, error = 1, rev_tick = 0.
- FAULT:
  - error stays high regardless of input; rev_count holds; phase_index = 0.
  - clear_error = 1 → IDLE: error = 0, rev_count = 0.
- clear_error in any state other than FAULT is ignored.
- Simultaneous events:
  - clear_error with a bad pattern in FAULT: the clear wins; go to IDLE.
  - A bad pattern at the same edge a revolution would complete: the fault wins; no tick, no increment.
- phase_index = encoded index of the hot bit of the sampled sequence when the next state is LOCKED, else 0.
- Reset mid-operation in any state: full return to reset values; lock must be re-acquired.

Decomposition:
- Shared package / include `ring_pkg`:
  - FSM state encodings (IDLE=0, SYNC=1, LOCKED=2, FAULT=3).
  - Default WIDTH constant.
  - Function rotl(prev).
  - Function is_onehot(v).
- One sub-module, `onehot_encoder`: combinational WIDTH → clog2(WIDTH) index plus valid flag. Used for phase_index and onehot detection.

Test Plan:
1. Reset is high for the first 100 ns, clock period 100 ns. During and just after reset: locked = 0, error = 0, rev_tick = 0, rev_count = 0, phase_index = 0.
2. Drive 001, 010, 100, 001, 010 on successive edges (LOCK_COUNT = 2):
   - locked = 1 after the 3rd edge, phase_index = 2.
   - 4th edge: rev_tick = 1 for one cycle, rev_count = 1, phase_index = 0.
   - 5th edge: phase_index = 1.
3. While locked, inject 011:
   - Next edge: locked = 0, error = 1.
   - error stays 1 over 5 further valid patterns.
   - Pulse clear_error: error = 0, rev_count = 0; lock is regained after 3 valid samples.
4. Drive reverse rotation 001, 100, 010, 001 repeatedly: locked stays 0 and error stays 0 indefinitely.
5. REV_WIDTH = 2, locked, drive 5 full revolutions: rev_count goes 1, 2, 3, 0, 1; rev_tick pulses 5 times.
6. Assert reset mid-cycle while LOCKED with rev_count = 3: all outputs go to 0 before the next clock edge. After release, lock is re-acquired from IDLE.
